// File: rtl/frame_decode.sv
// Modified Miller frame decoder: turns PCD X/Y/Z/ERROR sequences into a bit stream with SOC/EOC/error strobes.
// Optional build macro FRAME_DECODE_PARITY_EN strips and checks odd parity on every 9th bit.
module frame_decode #(
    parameter int MAX_FRAME_BITS = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] seq,
    input  logic       seq_valid,
    input  logic       seq_idle,
    output logic       soc,
    output logic       eoc,
    output logic       error,
    output logic       data,
    output logic       data_valid,
`ifdef FRAME_DECODE_PARITY_EN
    output logic       parity_error,
`endif
    output logic       in_frame
);

    // Sequence encoding shared with sequence_decode.
    localparam logic [1:0] SEQ_X   = 2'd0;
    localparam logic [1:0] SEQ_Y   = 2'd1;
    localparam logic [1:0] SEQ_Z   = 2'd2;
    localparam logic [1:0] SEQ_ERR = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam int             CW      = $clog2(MAX_FRAME_BITS + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_FRAME_BITS);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          idle_q;
    logic          soc_q, soc_d;
    logic          eoc_q, eoc_d;
    logic          err_q, err_d;
    logic          data_q, data_d;
    logic          dv_q, dv_d;
    logic          in_frame_q, in_frame_d;
    logic          emit_s;
    logic          idle_rise_s;

`ifdef FRAME_DECODE_PARITY_EN
    logic [3:0]    pidx_q, pidx_d;
    logic          pacc_q, pacc_d;
    logic          perr_q, perr_d;

    // Odd parity: data bits XOR parity bit must be 1.
    function automatic logic parity_bad(input logic acc, input logic pbit);
        return ~(acc ^ pbit);
    endfunction
`endif

    assign idle_rise_s = seq_idle & ~idle_q;

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        soc_d      = 1'b0;
        eoc_d      = 1'b0;
        err_d      = 1'b0;
        data_d     = data_q;
        dv_d       = 1'b0;
        in_frame_d = in_frame_q;
        emit_s     = 1'b0;
`ifdef FRAME_DECODE_PARITY_EN
        pidx_d     = pidx_q;
        pacc_d     = pacc_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (seq_valid) begin
                    if (seq == SEQ_Z) begin
                        soc_d      = 1'b1;
                        in_frame_d = 1'b1;
                        cnt_d      = '0;
                        pend_d     = 1'b0;
                        state_d    = ST_FIRST;
`ifdef FRAME_DECODE_PARITY_EN
                        pidx_d     = 4'd0;
                        pacc_d     = 1'b0;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (seq_valid) begin
                    case (seq)
                        SEQ_X: begin
                            pend_d  = 1'b1;
                            state_d = ST_DATA;
                        end
                        SEQ_Z: begin
                            pend_d  = 1'b0;
                            state_d = ST_DATA;
                        end
                        default: begin
                            err_d      = 1'b1;
                            in_frame_d = 1'b0;
                            state_d    = ST_WAIT;
                        end
                    endcase
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_DATA: begin
                if (seq_valid) begin
                    case (seq)
                        SEQ_X: begin
                            emit_s = 1'b1;
                            pend_d = 1'b1;
                        end
                        SEQ_Z: begin
                            if (pend_q) begin
                                err_d      = 1'b1;
                                in_frame_d = 1'b0;
                                state_d    = ST_WAIT;
                            end else begin
                                emit_s = 1'b1;
                                pend_d = 1'b0;
                            end
                        end
                        SEQ_Y: begin
                            if (pend_q) begin
                                emit_s = 1'b1;
                                pend_d = 1'b0;
                            end else begin
                                // Trailing logic 0 belongs to EOC and is not data.
                                eoc_d      = 1'b1;
                                in_frame_d = 1'b0;
                                state_d    = ST_WAIT;
                            end
                        end
                        default: begin
                            err_d      = 1'b1;
                            in_frame_d = 1'b0;
                            state_d    = ST_WAIT;
                        end
                    endcase
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (seq_idle) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            if (cnt_q == MAX_CNT) begin
                err_d      = 1'b1;
                in_frame_d = 1'b0;
                state_d    = ST_WAIT;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
`ifdef FRAME_DECODE_PARITY_EN
                if (pidx_q == 4'd8) begin
                    perr_d = parity_bad(pacc_q, pend_q);
                    pidx_d = 4'd0;
                    pacc_d = 1'b0;
                end else begin
                    dv_d   = 1'b1;
                    data_d = pend_q;
                    pidx_d = pidx_q + 4'd1;
                    pacc_d = pacc_q ^ pend_q;
                end
`else
                dv_d   = 1'b1;
                data_d = pend_q;
`endif
            end
        end else begin
            cnt_d = cnt_d;
        end

        // Idle without EOC aborts the frame; it outranks a bit emitted in the same tick.
        if (idle_rise_s && ((state_q == ST_FIRST) || (state_q == ST_DATA)) && !eoc_d && !err_d) begin
            err_d      = 1'b1;
            dv_d       = 1'b0;
            in_frame_d = 1'b0;
            pend_d     = 1'b0;
            state_d    = ST_IDLE;
`ifdef FRAME_DECODE_PARITY_EN
            perr_d     = 1'b0;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            idle_q     <= 1'b0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= 1'b0;
            dv_q       <= 1'b0;
            in_frame_q <= 1'b0;
`ifdef FRAME_DECODE_PARITY_EN
            pidx_q     <= 4'd0;
            pacc_q     <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            idle_q     <= seq_idle;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            err_q      <= err_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            in_frame_q <= in_frame_d;
`ifdef FRAME_DECODE_PARITY_EN
            pidx_q     <= pidx_d;
            pacc_q     <= pacc_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign soc        = soc_q;
    assign eoc        = eoc_q;
    assign error      = err_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign in_frame   = in_frame_q;
`ifdef FRAME_DECODE_PARITY_EN
    assign parity_error = perr_q;
`endif

endmodule
